bit_scatter_32: RTL
===================

# bit_scatter_32

Serial-to-parallel word assembler for the processor's 1-bit data paths. It accepts a stream of single bits through a valid/ready handshake and scatters each bit into the addressed position of a 32-bit accumulator through a one-hot write decoder. A completed word, or a short word ended early by `in_last`, is handed to a double-buffered output register with its own valid/ready handshake. It sits wherever a serial source must be turned back into a 32-bit word, for example the input controller and debug shift ports feeding the register file.

## Interface
- `MSB_FIRST`, default 0. 0: first accepted bit lands in bit 0. 1: first accepted bit lands in bit 31.
- `clock` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: `in_bit` is valid this cycle.
- `in_ready` out 1: the block accepts a bit this cycle.
- `in_bit` in 1: serial data bit.
- `in_last` in 1: qualifies `in_bit` as the final bit of a short word; ignored unless `in_valid`.
- `out_valid` out 1: `out_word` and `out_len` hold a completed word.
- `out_ready` in 1: consumer takes the word this cycle.
- `out_word` out 32: assembled word; positions never written are 0.
- `out_len` out 6: number of bits in `out_word`, range 1..32.

## Operation
- Accept event: `in_valid & in_ready`. Hand-off event: `out_valid & out_ready`.
- `ptr` is a 5-bit position counter.
  - Write position is `ptr` when `MSB_FIRST=0`, `31-ptr` when `MSB_FIRST=1`.
  - `decoder_5_32` turns the write position into a one-hot write enable; only the enabled accumulator bit loads `in_bit`.
- The word completes on an accept with `ptr==31` or `in_last==1`. Length is `ptr+1`.
- States:
  - FILL: `in_ready=1`.
    - Accept, word not complete: `ptr` increments by 1.
    - Accept, word completes, output slot free (`!out_valid` or hand-off this cycle): the accumulator, including this cycle's bit, transfers to `out_word`; `out_len` loads `ptr+1`; `out_valid` goes 1; the accumulator clears to 0; `ptr` goes to 0. State stays FILL.
    - Accept, word completes, output slot occupied with no hand-off: the bit is written, the length is latched, and the state goes to WAIT.
  - WAIT: `in_ready=0`. On hand-off, the accumulator and latched length transfer to the output, the accumulator clears, `ptr` goes to 0, and the state returns to FILL.
- A hand-off with nothing to transfer clears `out_valid` to 0; `out_word` and `out_len` keep their stale values.
- The accumulator always clears on transfer, so bits not written in a short word read 0.
- `in_last` on the 32nd bit is legal and gives `out_len=32`.
- `in_ready` is combinational from state only; it never depends on `in_valid`. `out_valid` is registered.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state FILL, `ptr=0`, accumulator 0;
  - `out_valid=0`, `out_word=0`, `out_len=0`;
  - `in_ready=1`.
- Reset asserted mid-word discards the partial word and any held output with no hand-off.
- Latency: `out_valid` rises on the clock edge that accepts the completing bit, i.e. visible the cycle after that bit is presented.
- Throughput:
  - One bit per cycle sustained when the consumer keeps up.
  - Back-to-back words with no bubble when `out_ready=1`: a hand-off and a completing accept in the same cycle both take effect, and the new word replaces the old one.
- Minimum word spacing is 1 cycle, e.g. consecutive `in_last` on every bit gives one 1-bit word per cycle.
- In WAIT, inputs are ignored. The upstream must hold `in_bit` and `in_last` until accepted; the block never drops an accepted bit.

## Structure
- Shared package/header `bit_scatter_pkg`:
  - `WORD_W=32`, `PTR_W=5`, `LEN_W=6`;
  - state encodings `ST_FILL=1'b0`, `ST_WAIT=1'b1`.
- Sub-module `decoder_5_32`: combinational 5-bit index to 32-bit one-hot plus an enable input.
  - This is the inverse of the existing 32:1 read mux and is reused by the register-file write port.
- Top level contains `ptr`, the state flop, the accumulator, the length latch and the output register.

## Test plan
- Reset, then 32 bits of 0xA5A5_F00F LSB-first with `MSB_FIRST=0`, `out_ready=1` -> one cycle after the 32nd accept: `out_valid=1`, `out_word=0xA5A5F00F`, `out_len=32`.
- `MSB_FIRST=1`, stream bits 1,0,1,1 with `in_last` on the 4th -> `out_word=0xB0000000`, `out_len=4`.
- `out_ready=0`, send two full words -> second completion enters WAIT, `in_ready=0`. Raise `out_ready` -> first word handed off, second word presented next cycle, `in_ready=1`.
- Continuous `in_valid` and `out_ready=1` for 96 bits -> three words, `out_valid` high for exactly one cycle per word, no stall cycles.
- `in_last` on every bit for 4 cycles with bits 1,0,1,1 -> four words with `out_len=1` and `out_word` 1,0,1,1.
- Assert `reset` after 10 bits, then resume with 32 fresh bits -> output is exactly the 32 fresh bits and no partial word ever appears.

Source files
------------

// File: rtl/bit_scatter_pkg.sv
// Shared widths and FSM encoding for the serial-to-parallel word assembler.
package bit_scatter_pkg;
    localparam int WORD_W = 32;
    localparam int PTR_W  = 5;
    localparam int LEN_W  = 6;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_WAIT = 1'b1
    } state_e;
endpackage

// File: rtl/bit_scatter_32_if.sv
// Bit-in / word-out handshake bundle for bit_scatter_32.
interface bit_scatter_32_if;
    import bit_scatter_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_bit;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;
    logic [LEN_W-1:0]  out_len;

    // Producer of bits / consumer of words.
    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_word, out_len
    );

    // The assembler itself.
    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_word, out_len
    );
endinterface

// File: rtl/bit_scatter_32_decoder.sv
// 5-bit index to 32-bit one-hot write enable; all zero when en_i is low.
module decoder_5_32 (
    input  logic [4:0]  idx_i,
    input  logic        en_i,
    output logic [31:0] onehot_o
);
    for (genvar g = 0; g < 32; g++) begin : g_dec
        assign onehot_o[g] = en_i && (idx_i == 5'(g));
    end
endmodule

// File: rtl/bit_scatter_32.sv
// Serial bit stream to 32-bit word assembler with a one-word output register
// plus a held accumulator, giving double buffering against a stalled consumer.
module bit_scatter_32
    import bit_scatter_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    bit_scatter_32_if.slave  bus
);
    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_word_q, out_word_d;
    logic [LEN_W-1:0]  out_len_q, out_len_d;

    logic              in_ready;
    logic              accept, handoff, complete, slot_free;
    logic [PTR_W-1:0]  wpos;
    logic [WORD_W-1:0] we, acc_wr;
    logic [LEN_W-1:0]  len_now;

    assign in_ready  = (state_q == ST_FILL);
    assign accept    = bus.in_valid && in_ready;
    assign handoff   = out_valid_q && bus.out_ready;
    assign complete  = accept && ((ptr_q == PTR_W'(WORD_W-1)) || bus.in_last);
    assign slot_free = !out_valid_q || handoff;
    assign len_now   = {1'b0, ptr_q} + LEN_W'(1);
    // 31-ptr is the bitwise inverse of a 5-bit pointer.
    assign wpos      = MSB_FIRST ? ~ptr_q : ptr_q;

    decoder_5_32 u_dec (
        .idx_i    (wpos),
        .en_i     (accept),
        .onehot_o (we)
    );

    assign acc_wr = (acc_q & ~we) | (we & {WORD_W{bus.in_bit}});

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        acc_d       = acc_q;
        len_d       = len_q;
        out_valid_d = handoff ? 1'b0 : out_valid_q;
        out_word_d  = out_word_q;
        out_len_d   = out_len_q;
        unique case (state_q)
            ST_FILL: begin
                if (accept) begin
                    if (!complete) begin
                        acc_d = acc_wr;
                        ptr_d = ptr_q + PTR_W'(1);
                    end else if (slot_free) begin
                        out_word_d  = acc_wr;
                        out_len_d   = len_now;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        ptr_d       = '0;
                    end else begin
                        // Consumer stalled: park the finished word in the accumulator.
                        acc_d   = acc_wr;
                        len_d   = len_now;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (handoff) begin
                    out_word_d  = acc_q;
                    out_len_d   = len_q;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    ptr_d       = '0;
                    state_d     = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FILL;
            ptr_q       <= '0;
            acc_q       <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_len_q   <= out_len_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_len   = out_len_q;
endmodule
